// File: rtl/cell_stream_arb.sv
// cell_stream_arb
// Round-robin scheduler that shares the single parallel injection port of the
// cell stream packet MUX between four requesters. Requester i always targets
// destination stream i: 0 Cell CCW, 1 Cell CW, 2 BPM CCW, 3 BPM CW.
// A destination is held off for BUSY_CYCLES after each strobe so that its
// serializer is never re-strobed while it is still emitting. Any two strobes
// are also separated by at least GAP_CYCLES idle cycles.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   enable             when low, no new grants are made (counters keep running)
//   req[3:0]           requester i holds a packet for destination i
//   req_header/datax/datay/datas[127:0]
//                      per-requester packet slots, 32 bits each, slot i at
//                      bits [32*i+31:32*i]
//   ack[3:0]           one-cycle grant pulse back to the granted requester
//   stream_mux_strobe  one-cycle packet strobe to the MUX
//   stream_mux_sel     destination index, valid with the strobe
//   stream_in_*        header/X/Y/S of the granted packet
//   dest_busy[3:0]     destination i is inside its hold-off window
//   issued_count       number of strobes issued, wraps silently

module cell_stream_arb #(
   parameter int unsigned BUSY_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 0,
   parameter int unsigned COUNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [3:0]         req,
   input  logic [127:0]       req_header,
   input  logic [127:0]       req_datax,
   input  logic [127:0]       req_datay,
   input  logic [127:0]       req_datas,
   output logic [3:0]         ack,
   output logic               stream_mux_strobe,
   output logic [1:0]         stream_mux_sel,
   output logic [31:0]        stream_in_header,
   output logic [31:0]        stream_in_datax,
   output logic [31:0]        stream_in_datay,
   output logic [31:0]        stream_in_datas,
   output logic [3:0]         dest_busy,
   output logic [COUNT_W-1:0] issued_count
);

   localparam logic [3:0] BUSY_LD = 4'(BUSY_CYCLES);
   localparam logic [3:0] GAP_LD  = 4'(GAP_CYCLES);

   logic [3:0] busy_cnt [4];
   logic [3:0] gap_cnt;
   logic [1:0] ptr;         // last granted index

   logic [3:0] eligible;
   logic       grant_vld;
   logic [1:0] grant_idx;
   logic [1:0] cand;
   logic [6:0] slot_base;

   // A requester that is being acked this cycle is ignored, so a held req
   // is read as the requester's next packet only once ack has dropped.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         eligible[i] = req[i] && (busy_cnt[i] == 4'd0) && (gap_cnt == 4'd0)
                       && enable && !ack[i];
      end
   end

   // Search starts one past the last winner and wraps; k=4 lands on ptr
   // itself so the last winner has lowest priority.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = ptr;
      cand      = ptr;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr + 2'(k);
         if (!grant_vld && eligible[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign slot_base = {grant_idx, 5'b00000};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         dest_busy[i] = (busy_cnt[i] != 4'd0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stream_mux_strobe <= 1'b0;
         stream_mux_sel    <= 2'd0;
         ack               <= 4'd0;
         stream_in_header  <= 32'd0;
         stream_in_datax   <= 32'd0;
         stream_in_datay   <= 32'd0;
         stream_in_datas   <= 32'd0;
         issued_count      <= '0;
         gap_cnt           <= 4'd0;
         ptr               <= 2'd3;
         for (int i = 0; i < 4; i++) begin
            busy_cnt[i] <= 4'd0;
         end
      end else begin
         stream_mux_strobe <= grant_vld;
         ack               <= grant_vld ? (4'b0001 << grant_idx) : 4'b0000;

         // Data outputs only move on a grant; between strobes they hold.
         if (grant_vld) begin
            stream_mux_sel   <= grant_idx;
            stream_in_header <= req_header[slot_base +: 32];
            stream_in_datax  <= req_datax[slot_base +: 32];
            stream_in_datay  <= req_datay[slot_base +: 32];
            stream_in_datas  <= req_datas[slot_base +: 32];
            ptr              <= grant_idx;
            issued_count     <= issued_count + COUNT_W'(1);
         end

         for (int i = 0; i < 4; i++) begin
            if (grant_vld && (grant_idx == 2'(i))) begin
               busy_cnt[i] <= BUSY_LD;
            end else if (busy_cnt[i] != 4'd0) begin
               busy_cnt[i] <= busy_cnt[i] - 4'd1;
            end
         end

         if (grant_vld) begin
            gap_cnt <= GAP_LD;
         end else if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_cell_stream_arb.sv
// Bench for cell_stream_arb. Two instances share the stimulus: instance 0
// uses the default parameters (GAP_CYCLES=0), instance 1 uses GAP_CYCLES=2.
// A timestamp-based model predicts both every cycle; directed sections pin
// the model with hand-computed literals.

module tb_cell_stream_arb;

   localparam int BUSY = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b1;
   logic [3:0]   req = 4'd0;
   logic [127:0] req_header = '0;
   logic [127:0] req_datax = '0;
   logic [127:0] req_datay = '0;
   logic [127:0] req_datas = '0;

   logic [3:0]  ack       [2];
   logic        strobe    [2];
   logic [1:0]  sel       [2];
   logic [31:0] hdr       [2];
   logic [31:0] dx        [2];
   logic [31:0] dy        [2];
   logic [31:0] ds        [2];
   logic [3:0]  dbusy     [2];
   logic [15:0] cnt       [2];

   int total = 0;
   int bad = 0;
   bit go = 0;

   always #5 clk = ~clk;

   cell_stream_arb #(.BUSY_CYCLES(4), .GAP_CYCLES(0), .COUNT_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .req(req),
      .req_header(req_header), .req_datax(req_datax),
      .req_datay(req_datay), .req_datas(req_datas),
      .ack(ack[0]), .stream_mux_strobe(strobe[0]), .stream_mux_sel(sel[0]),
      .stream_in_header(hdr[0]), .stream_in_datax(dx[0]),
      .stream_in_datay(dy[0]), .stream_in_datas(ds[0]),
      .dest_busy(dbusy[0]), .issued_count(cnt[0]));

   cell_stream_arb #(.BUSY_CYCLES(4), .GAP_CYCLES(2), .COUNT_W(16)) dut_g (
      .clk(clk), .rst(rst), .enable(enable), .req(req),
      .req_header(req_header), .req_datax(req_datax),
      .req_datay(req_datay), .req_datas(req_datas),
      .ack(ack[1]), .stream_mux_strobe(strobe[1]), .stream_mux_sel(sel[1]),
      .stream_in_header(hdr[1]), .stream_in_datax(dx[1]),
      .stream_in_datay(dy[1]), .stream_in_datas(ds[1]),
      .dest_busy(dbusy[1]), .issued_count(cnt[1]));

   // ---------------- behavioural model ----------------
   // A destination may be granted again once BUSY+1 edges have passed since
   // its last grant; any grant needs GAP+1 edges since the previous grant.
   int          ecount = 0;
   int          last_dest [2][4];
   int          last_any  [2];
   int          ptr_m     [2];
   logic        e_strobe  [2];
   logic [1:0]  e_sel     [2];
   logic [3:0]  e_ack     [2];
   logic [3:0]  e_busy    [2];
   logic [31:0] e_hdr     [2];
   logic [31:0] e_x       [2];
   logic [31:0] e_y       [2];
   logic [31:0] e_s       [2];
   logic [15:0] e_cnt     [2];

   task automatic mreset();
      for (int n = 0; n < 2; n++) begin
         for (int i = 0; i < 4; i++) last_dest[n][i] = -1000;
         last_any[n] = -1000;
         ptr_m[n]    = 3;
         e_strobe[n] = 1'b0;
         e_sel[n]    = 2'd0;
         e_ack[n]    = 4'd0;
         e_busy[n]   = 4'd0;
         e_hdr[n]    = 32'd0;
         e_x[n]      = 32'd0;
         e_y[n]      = 32'd0;
         e_s[n]      = 32'd0;
         e_cnt[n]    = 16'd0;
      end
   endtask

   task automatic mstep();
      int gap;
      int g;
      int idx;
      bit el [4];
      ecount++;
      for (int n = 0; n < 2; n++) begin
         gap = (n == 0) ? 0 : 2;
         for (int i = 0; i < 4; i++) begin
            el[i] = req[i] && enable && !e_ack[n][i]
                    && (ecount - last_dest[n][i] >= BUSY + 1)
                    && (ecount - last_any[n] >= gap + 1);
         end
         g = -1;
         for (int k = 1; k <= 4; k++) begin
            idx = (ptr_m[n] + k) % 4;
            if (g < 0 && el[idx]) g = idx;
         end
         if (g >= 0) begin
            e_strobe[n] = 1'b1;
            e_sel[n]    = 2'(g);
            e_ack[n]    = 4'(1 << g);
            e_hdr[n]    = req_header[32*g +: 32];
            e_x[n]      = req_datax[32*g +: 32];
            e_y[n]      = req_datay[32*g +: 32];
            e_s[n]      = req_datas[32*g +: 32];
            e_cnt[n]    = e_cnt[n] + 16'd1;
            ptr_m[n]    = g;
            last_dest[n][g] = ecount;
            last_any[n] = ecount;
         end else begin
            e_strobe[n] = 1'b0;
            e_ack[n]    = 4'd0;
         end
         for (int i = 0; i < 4; i++) begin
            e_busy[n][i] = (ecount - last_dest[n][i]) < BUSY;
         end
      end
   endtask

   initial begin
      mreset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) mreset();
         else mstep();
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (go) begin
            for (int n = 0; n < 2; n++) begin
               chk($sformatf("m%0d.strobe", n), 64'(strobe[n]), 64'(e_strobe[n]));
               chk($sformatf("m%0d.sel", n), 64'(sel[n]), 64'(e_sel[n]));
               chk($sformatf("m%0d.ack", n), 64'(ack[n]), 64'(e_ack[n]));
               chk($sformatf("m%0d.header", n), 64'(hdr[n]), 64'(e_hdr[n]));
               chk($sformatf("m%0d.datax", n), 64'(dx[n]), 64'(e_x[n]));
               chk($sformatf("m%0d.datay", n), 64'(dy[n]), 64'(e_y[n]));
               chk($sformatf("m%0d.datas", n), 64'(ds[n]), 64'(e_s[n]));
               chk($sformatf("m%0d.dest_busy", n), 64'(dbusy[n]), 64'(e_busy[n]));
               chk($sformatf("m%0d.count", n), 64'(cnt[n]), 64'(e_cnt[n]));
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 4'd0;
      enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         req_header[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
         req_datax[32*i +: 32]  = 32'h0000_1000 + 32'(i);
         req_datay[32*i +: 32]  = 32'h0000_2000 + 32'(i);
         req_datas[32*i +: 32]  = 32'h0000_3000 + 32'(i);
      end
      do_reset();
      go = 1;

      // reset state
      @(negedge clk);
      chk("rst.strobe", 64'(strobe[0]), 64'd0);
      chk("rst.count", 64'(cnt[0]), 64'd0);
      chk("rst.busy", 64'(dbusy[0]), 64'd0);

      // single request
      req_header[31:0] = 32'hA000_0001;
      req_datax[31:0]  = 32'd1;
      req_datay[31:0]  = 32'd2;
      req_datas[31:0]  = 32'd3;
      req = 4'b0001;
      @(negedge clk);
      chk("single.strobe", 64'(strobe[0]), 64'd1);
      chk("single.sel", 64'(sel[0]), 64'd0);
      chk("single.header", 64'(hdr[0]), 64'hA000_0001);
      chk("single.x", 64'(dx[0]), 64'd1);
      chk("single.y", 64'(dy[0]), 64'd2);
      chk("single.s", 64'(ds[0]), 64'd3);
      chk("single.ack", 64'(ack[0]), 64'b0001);
      chk("single.count", 64'(cnt[0]), 64'd1);
      req = 4'b0000;
      @(negedge clk);
      chk("single.strobe_off", 64'(strobe[0]), 64'd0);
      chk("single.ack_off", 64'(ack[0]), 64'd0);
      repeat (5) @(negedge clk);

      // all four requesting
      do_reset();
      req = 4'b1111;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 5) begin
            chk("all4.gap_strobe", 64'(strobe[0]), 64'd0);
         end else begin
            chk($sformatf("all4.strobe%0d", c), 64'(strobe[0]), 64'd1);
            chk($sformatf("all4.sel%0d", c), 64'(sel[0]), (c == 6) ? 64'd0 : 64'(c - 1));
         end
         if (c == 2) chk("all4.x1", 64'(dx[0]), 64'h0000_1001);
         if (c == 6) chk("all4.count", 64'(cnt[0]), 64'd5);
      end
      req = 4'b0000;
      repeat (5) @(negedge clk);

      // one continuous requester
      do_reset();
      req = 4'b0100;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         chk($sformatf("cont.strobe%0d", c), 64'(strobe[0]), 64'((c % 5) == 1));
         chk($sformatf("cont.busy%0d", c), 64'(dbusy[0][2]), 64'(((c - 1) % 5) != 4));
         if ((c % 5) == 1) chk($sformatf("cont.sel%0d", c), 64'(sel[0]), 64'd2);
      end
      req = 4'b0000;
      repeat (5) @(negedge clk);

      // gap build on the GAP_CYCLES=2 instance
      do_reset();
      req = 4'b0011;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         chk($sformatf("gap.strobe%0d", c), 64'(strobe[1]), 64'((c % 3) == 1));
         if ((c % 3) == 1) chk($sformatf("gap.sel%0d", c), 64'(sel[1]), 64'(((c - 1) / 3) % 2));
      end
      req = 4'b0000;
      repeat (5) @(negedge clk);

      // enable gating
      do_reset();
      enable = 1'b0;
      req = 4'b1000;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         chk($sformatf("en.strobe%0d", c), 64'(strobe[0]), 64'd0);
         chk($sformatf("en.ack%0d", c), 64'(ack[0]), 64'd0);
      end
      enable = 1'b1;
      @(negedge clk);
      chk("en.strobe", 64'(strobe[0]), 64'd1);
      chk("en.sel", 64'(sel[0]), 64'd3);
      chk("en.ack", 64'(ack[0]), 64'b1000);
      req = 4'b0000;
      repeat (5) @(negedge clk);

      // reset during the second strobe of a burst
      do_reset();
      req = 4'b1111;
      @(negedge clk);
      chk("mid.first_sel", 64'(sel[0]), 64'd0);
      @(posedge clk);
      #1;
      chk("mid.second_strobe", 64'(strobe[0]), 64'd1);
      chk("mid.second_sel", 64'(sel[0]), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid.strobe_clr", 64'(strobe[0]), 64'd0);
      chk("mid.ack_clr", 64'(ack[0]), 64'd0);
      chk("mid.count_clr", 64'(cnt[0]), 64'd0);
      chk("mid.busy_clr", 64'(dbusy[0]), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid.after_strobe", 64'(strobe[0]), 64'd1);
      chk("mid.after_sel", 64'(sel[0]), 64'd0);
      chk("mid.after_count", 64'(cnt[0]), 64'd1);
      req = 4'b0000;
      repeat (6) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cell_stream_arb.md
Name: cell_stream_arb

Overview:
- Round-robin arbiter/scheduler in front of the cell stream packet MUX input.
- Shares the single parallel injection port (stream_mux_strobe, stream_mux_sel, header/x/y/s) between four packet requesters, one per destination stream: 0 Cell CCW, 1 Cell CW, 2 BPM CCW, 3 BPM CW.
- Enforces a per-destination busy time so a destination's serializer is never re-strobed while still emitting a packet.
- Enforces a global minimum gap between any two strobes.

Parameters:
- BUSY_CYCLES, 4: idle cycles a destination is held off after its strobe; range 1..15.
- GAP_CYCLES, 0: extra idle cycles required between any two strobes; range 0..15.
- COUNT_W, 16: width of issued_count.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- enable  input  1  when low, no new grants are made
- req  input  4  req[i]: requester i holds a packet for destination i
- req_header  input  128  packet headers; bits [32*i+31:32*i] belong to requester i
- req_datax  input  128  X data, same packing as req_header
- req_datay  input  128  Y data, same packing
- req_datas  input  128  S data, same packing
- ack  output  4  one-cycle grant pulse to requester i
- stream_mux_strobe  output  1  one-cycle packet strobe to the MUX
- stream_mux_sel  output  2  destination index, valid with the strobe
- stream_in_header  output  32  header of the granted packet
- stream_in_datax  output  32  X data of the granted packet
- stream_in_datay  output  32  Y data of the granted packet
- stream_in_datas  output  32  S data of the granted packet
- dest_busy  output  4  dest_busy[i] high while destination i's hold-off counter is nonzero
- issued_count  output  COUNT_W  total strobes issued; wraps modulo 2^COUNT_W

Behaviour:
- All outputs are registered.
- Under rst (asynchronous), immediately clear:
  - strobe, sel, ack, all data outputs, issued_count, dest_busy counters, gap counter;
  - RR pointer (last granted index) is set to 3, so index 0 has first priority.
- Eligibility, evaluated every cycle: eligible[i] = req[i] & (busy_cnt[i]==0) & (gap_cnt==0) & enable & ~ack[i].
  - While ack[i] is high, req[i] is ignored for that cycle; the requester may drop req or present its next packet.
- Grant: the first eligible index searched from pointer+1 mod 4 upward, wrapping.
  - If any index is eligible at edge t, then during the following cycle:
    - stream_mux_strobe=1, stream_mux_sel=i, and data outputs = slot i as sampled at edge t;
    - ack[i]=1;
    - pointer=i, issued_count increments.
  - Latency from req to strobe is one cycle.
- Requester rule: req[i] and its slot data stay stable from assertion until ack[i]. The arbiter never grants without a req.
- Per-destination hold-off:
  - On grant, busy_cnt[i] is loaded with BUSY_CYCLES, then decrements by 1 per cycle to 0.
  - dest_busy[i] = (busy_cnt[i]!=0).
  - Two strobes to the same destination are at least BUSY_CYCLES+1 cycles apart.
- Global gap:
  - On any grant, gap_cnt is loaded with GAP_CYCLES, then decrements to 0.
  - Any two strobes are at least GAP_CYCLES+1 cycles apart. With GAP_CYCLES=0, strobes to different destinations may occur back-to-back.
- Idle cycles: when no grant occurs, strobe=0 and ack=0, and data outputs hold their last values (don't-care for the consumer).
- enable low:
  - no grants; busy and gap counters keep counting down;
  - pending reqs wait;
  - a grant may occur on the first edge after enable rises.
- Simultaneous requests: exactly one grant per cycle. Losers keep requesting and are served in rotation, so every requester is served within 4 grants (no starvation).
- issued_count wraps from all-ones to 0 with no flag.
- rst asserted mid-burst: an in-flight strobe/ack is cancelled immediately; no partial state remains after release.

Test Plan:
- Single request: req=0001, header=0xA0000001, x=1, y=2, s=3.
  - Next cycle: strobe=1, sel=0, outputs A0000001/1/2/3, ack=0001, issued_count=1.
  - Strobe is high for exactly one cycle.
- All four requesting: req=1111 held, defaults.
  - Strobes on cycles t, t+1, t+2, t+3 with sel 0,1,2,3.
  - No strobe at t+4.
  - sel=0 again at t+5.
- One requester continuous: req=0100 held.
  - Strobes with sel=2 every 5 cycles; dest_busy[2] high for 4 cycles after each strobe.
- Gap build: GAP_CYCLES=2, req=0011 held.
  - Strobes with sel 0,1,0,1... spaced exactly 3 cycles apart.
- Enable gating: req=1000 with enable=0 for 10 cycles.
  - No strobe, ack stays 0.
  - Raise enable: strobe with sel=3 exactly one cycle later.
- Mid-burst reset: req=1111, assert rst during the second strobe.
  - strobe, ack and issued_count go to 0 with no clock edge.
  - After release with req=1111: first grant is sel=0.
